// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci sequencer: FSM state encoding,
// ALU opcodes driven toward the sibling ALU, and default widths.
package fib_pkg;

  localparam int DEF_SIZE  = 4;
  localparam int DEF_CNT_W = 4;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EMIT = 2'd1;
  localparam logic [1:0] ST_ADD  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/fib_sequencer.sv
// Issues ADDs to a sibling ALU to walk the Fibonacci sequence and streams each
// term out on a valid/ready port. Optional macro FIB_OVF_STOP_EN ends a run at
// the last exact (unwrapped) term instead of emitting wrapped values.
module fib_sequencer
  import fib_pkg::*;
#(
  parameter int         SIZE   = fib_pkg::DEF_SIZE,
  parameter int         CNT_W  = fib_pkg::DEF_CNT_W,
  parameter logic [2:0] OP_ADD = fib_pkg::OP_ADD,
  parameter logic [2:0] OP_NOP = fib_pkg::OP_NOP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_terms,
  output logic             busy,
  output logic [SIZE-1:0]  alu_in1,
  output logic [SIZE-1:0]  alu_in2,
  output logic [2:0]       alu_opcode,
  input  logic [SIZE-1:0]  alu_out,
  output logic [SIZE-1:0]  term,
  output logic             term_valid,
  input  logic             term_ready,
  output logic             term_last,
  output logic             done,
  output logic             ovf
);

  logic [1:0]       state;
  logic [SIZE-1:0]  a, b;
  logic             a_ovf, b_ovf, ovf_q;
  logic [CNT_W-1:0] idx, n_lat;
  logic             last_idx, last_c, early_stop;

  // An unsigned sum that came out smaller than an addend has wrapped.
  function automatic logic add_wrapped(input logic [SIZE-1:0] sum,
                                       input logic [SIZE-1:0] addend);
    return (sum < addend);
  endfunction

  assign last_idx = (idx == n_lat - CNT_W'(1));

`ifdef FIB_OVF_STOP_EN
  assign last_c     = last_idx | b_ovf;
  assign early_stop = term_ready & b_ovf & ~last_idx;
`else
  assign last_c     = last_idx;
  assign early_stop = 1'b0;
`endif

  assign busy       = (state != ST_IDLE);
  assign term_valid = (state == ST_EMIT);
  assign term       = a;
  assign term_last  = term_valid & last_c;
  assign done       = (state == ST_DONE);
  // A wrapped term raises ovf in the same cycle it is first presented.
  assign ovf        = ovf_q | (term_valid & a_ovf);
  assign alu_in1    = a;
  assign alu_in2    = b;
  assign alu_opcode = (state == ST_ADD) ? OP_ADD : OP_NOP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      a     <= '0;
      b     <= '0;
      a_ovf <= 1'b0;
      b_ovf <= 1'b0;
      idx   <= '0;
      n_lat <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            ovf_q <= 1'b0;
            n_lat <= n_terms;
            if (n_terms != '0) begin
              a     <= '0;
              b     <= SIZE'(1);
              a_ovf <= 1'b0;
              b_ovf <= 1'b0;
              idx   <= '0;
              state <= ST_EMIT;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_EMIT: begin
          ovf_q <= ovf_q | a_ovf | early_stop;
          if (term_ready) state <= last_c ? ST_DONE : ST_ADD;
        end
        ST_ADD: begin
          a     <= b;
          a_ovf <= b_ovf;
          b     <= alu_out;
          b_ovf <= b_ovf | add_wrapped(alu_out, b);
          idx   <= idx + CNT_W'(1);
          state <= ST_EMIT;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_sequencer.sv
// Directed-plus-random bench for fib_sequencer; the ALU sibling is modelled
// inline and expected terms come from plain integer Fibonacci arithmetic.
module tb_fib_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] n_terms = '0;
  logic       term_ready = 1'b0;
  logic       busy, term_valid, term_last, done, ovf;
  logic [3:0] alu_in1, alu_in2, alu_out, term;
  logic [2:0] alu_opcode;

  int total = 0;
  int bad = 0;

  int exp_term[16];
  bit exp_ovf[16];
  int exp_cnt;
  bit exp_fin;

  always #5 clk = ~clk;

  assign alu_out = (alu_opcode == 3'b001) ? 4'(alu_in1 + alu_in2) : 4'd0;

  fib_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_terms(n_terms), .busy(busy),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .term(term), .term_valid(term_valid),
    .term_ready(term_ready), .term_last(term_last), .done(done), .ovf(ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: true Fibonacci values, reduced mod 16 for the 4-bit port.
  task automatic build_model(input int n);
    int f0, f1, t;
    bit seen;
    f0 = 0; f1 = 1; seen = 0; exp_cnt = 0;
    for (int i = 0; i < n; i++) begin
`ifdef FIB_OVF_STOP_EN
      if (f0 >= 16) break;
`endif
      if (f0 >= 16) seen = 1;
      exp_term[i] = f0 % 16;
      exp_ovf[i]  = seen;
      exp_cnt++;
      t = f0 + f1; f0 = f1; f1 = t;
    end
    exp_fin = (exp_cnt < n) || (exp_cnt > 0 && exp_ovf[exp_cnt-1]);
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low 3 cycles at idx1.
  task automatic run(input int n, input int mode, input bit poke,
                     output int first_v, output int done_c);
    int k, c, hold;
    bit was_stall, got_done;
    logic [3:0] held;
    k = 0; hold = 0; was_stall = 0; got_done = 0; held = '0;
    first_v = -1; done_c = -1;
    build_model(n);
    @(negedge clk);
    n_terms = 4'(n); start = 1'b1; term_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; n_terms = 4'($urandom); c = 1;
    while (c < 200) begin
      start = poke && (c == 3);
      if (poke && c == 3) n_terms = 4'($urandom);
      chk("busy_run", busy, 1);
      if (done) begin
        chk("term_count", k, exp_cnt);
        chk("ovf_at_done", ovf, exp_fin);
        chk("valid_in_done", term_valid, 0);
        done_c = c; got_done = 1;
        break;
      end
      if (term_valid) begin
        if (first_v < 0) first_v = c;
        if (was_stall) chk("held_term", term, held);
        chk("no_extra_term", k < exp_cnt, 1);
        if (k < exp_cnt) begin
          chk($sformatf("term%0d", k), term, exp_term[k]);
          chk($sformatf("last%0d", k), term_last, k == exp_cnt - 1);
          chk($sformatf("ovf%0d", k), ovf, exp_ovf[k]);
        end
        chk("opcode_emit", alu_opcode, 3'b000);
        if (mode == 1) term_ready = 1'($urandom_range(0, 1));
        else if (mode == 2 && k == 1 && hold < 3) begin term_ready = 1'b0; hold++; end
        else term_ready = 1'b1;
        was_stall = !term_ready;
        held = term;
        if (term_ready) k++;
      end else begin
        chk("opcode_add", alu_opcode, 3'b001);
      end
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    if (!got_done) chk("done_timeout", got_done, 1);
    @(negedge clk);
    chk("busy_idle", busy, 0);
    chk("done_single", done, 0);
    chk("ovf_sticky", ovf, exp_fin);
  endtask

  initial begin
    int fv, dc, beats, n;
    bit found;

    // Reset state
    #12;
    chk("reset_outputs", {busy, alu_in1, alu_in2, alu_opcode, term, term_valid,
                          term_last, done, ovf}, 0);
    @(negedge clk); rst_n = 1'b1;

    // Reset during the idx3 beat
    @(negedge clk); n_terms = 4'd6; start = 1'b1; term_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    beats = 0; found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (term_valid && beats == 3) found = 1;
      else begin
        if (term_valid) beats++;
        @(negedge clk);
      end
    end
    chk("reach_idx3", found, 1);
    chk("idx3_term", term, 2);
    #1 rst_n = 1'b0;
    #1 chk("async_reset_outputs", {busy, alu_in1, alu_in2, alu_opcode, term,
                                   term_valid, term_last, done, ovf}, 0);
    @(negedge clk); chk("no_done_in_reset", done, 0);
    @(negedge clk); chk("no_done_in_reset2", done, 0);
    rst_n = 1'b1;
    run(2, 0, 0, fv, dc);
    chk("after_reset_done_cycle", dc, 4);

    // Nominal run, five terms
    run(5, 0, 0, fv, dc);
    chk("first_valid_cycle", fv, 1);
    chk("done_cycle_n5", dc, 10);

    // Backpressure at idx1
    run(4, 2, 0, fv, dc);
    chk("done_cycle_bp", dc, 11);

    // Zero terms
    run(0, 0, 0, fv, dc);
    chk("n0_done_cycle", dc, 1);
    chk("n0_no_valid", fv, -1);

    // start while busy is ignored
    run(6, 0, 1, fv, dc);
    chk("poke_done_cycle", dc, 12);

    // Overflow
    run(10, 0, 0, fv, dc);
    chk("ovf_done_cycle", dc, 2 * exp_cnt);

    // Random lengths with random backpressure
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 15);
      run(n, 1, 0, fv, dc);
    end
    run(15, 0, 0, fv, dc);
    chk("n15_done_cycle", dc, 2 * exp_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
